// File: rtl/snn_fixed_pkg.sv
// Shared fixed-point definitions for the SNN datapath (signed Q2.16).
// Used by spike_synapse, syn_delay_line and izhikevich_core.
package snn_fixed_pkg;

  // Default datapath width and fractional bit count
  localparam int SNN_N         = 18;
  localparam int SNN_FRAC_BITS = 16;

  // Default axonal delay-line depth, in apply-steps
  localparam int SNN_DELAY_MAX = 16;

  // Signed fixed-point word shared with the neuron core
  typedef logic signed [SNN_N-1:0] fix_t;

  // Largest representable value (just under +2.0)
  localparam fix_t FIX_MAX = 18'sh1_FFFF;

  // Smallest representable value (-2.0)
  localparam fix_t FIX_MIN = 18'sh2_0000;

endpackage

// File: rtl/syn_delay_line.sv
// Axonal delay line: a pending-spike vector that advances one slot per apply
// step. A spike sampled with delay=d is injected d-1 slots up the vector and
// so reaches slot 0, where it is reported as an arrival, d steps later.
module syn_delay_line
  import snn_fixed_pkg::*;
#(
  parameter int DELAY_MAX = SNN_DELAY_MAX
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         apply,
  input  logic                         spike_in,
  input  logic [$clog2(DELAY_MAX)-1:0] delay,
  output logic                         arrive
);

  localparam int DW = $clog2(DELAY_MAX);

  logic [DELAY_MAX-1:0] pend_reg;
  logic [DELAY_MAX-1:0] pend_next;
  logic [DELAY_MAX-1:0] inject;

  // One-hot injection point: slot delay-1, nothing when delay is zero
  for (genvar gi = 0; gi < DELAY_MAX; gi++) begin : g_inject
    assign inject[gi] = spike_in && (delay != '0) && (delay == DW'(gi + 1));
  end

  // Shift toward slot 0 and OR in the new spike; in-flight entries keep moving
  // regardless of later delay changes
  assign pend_next = {1'b0, pend_reg[DELAY_MAX-1:1]} | inject;

  // A zero-delay spike and an entry reaching slot 0 merge into one arrival
  assign arrive = pend_reg[0] | (spike_in & (delay == '0));

  // Pending-vector register, advanced only on apply steps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_reg <= '0;
    end else if (apply) begin
      pend_reg <= pend_next;
    end
  end

endmodule

// File: rtl/spike_synapse.sv
// Exponentially decaying current-based synapse with axonal delay and bias.
// Optional feature macro: SPIKE_SYNAPSE_SATURATE_EN -- when defined, results
// clamp to the Q2.16 range and a sticky overflow flag is raised; otherwise
// results wrap and overflow stays 0.
module spike_synapse
  import snn_fixed_pkg::*;
#(
  parameter int N         = SNN_N,
  parameter int DELAY_MAX = SNN_DELAY_MAX
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         apply,
  input  logic                         spike_in,
  input  logic signed [N-1:0]          weight,
  input  logic [3:0]                   tau_shift,
  input  logic [$clog2(DELAY_MAX)-1:0] delay,
  input  logic signed [N-1:0]          bias,
  output logic signed [N-1:0]          i_out,
  output logic                         spike_delayed,
  output logic                         overflow
);

  // Two guard bits so one add and one subtract can never wrap internally
  localparam int W = N + 2;

  logic                arrive;
  logic signed [N-1:0] syn_reg;
  logic signed [N-1:0] i_out_reg;
  logic                spike_delayed_reg;
  logic signed [N-1:0] decay;
  logic signed [W-1:0] syn_wide;
  logic signed [W-1:0] sum_wide;
  logic signed [N-1:0] syn_next;
  logic signed [N-1:0] i_next;

  syn_delay_line #(
    .DELAY_MAX (DELAY_MAX)
  ) u_delay_line (
    .clk      (clk),
    .reset    (reset),
    .apply    (apply),
    .spike_in (spike_in),
    .delay    (delay),
    .arrive   (arrive)
  );

  // Decay plus weight accumulation, then bias addition, all in W bits
  always_comb begin
    decay    = syn_reg >>> tau_shift;
    syn_wide = {{2{syn_reg[N-1]}}, syn_reg} - {{2{decay[N-1]}}, decay};
    if (arrive) begin
      syn_wide = syn_wide + {{2{weight[N-1]}}, weight};
    end
    sum_wide = {{2{syn_next[N-1]}}, syn_next} + {{2{bias[N-1]}}, bias};
  end

`ifdef SPIKE_SYNAPSE_SATURATE_EN
  localparam logic signed [W-1:0] MAX_W = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_W = {3'b111, {(N-1){1'b0}}};
  localparam logic signed [N-1:0] MAX_N = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

  logic syn_clip;
  logic i_clip;
  logic overflow_reg;

  // Clamp both reductions to the representable range
  always_comb begin
    syn_clip = (syn_wide > MAX_W) || (syn_wide < MIN_W);
    syn_next = syn_clip ? (syn_wide[W-1] ? MIN_N : MAX_N) : syn_wide[N-1:0];
    i_clip   = (sum_wide > MAX_W) || (sum_wide < MIN_W);
    i_next   = i_clip ? (sum_wide[W-1] ? MIN_N : MAX_N) : sum_wide[N-1:0];
  end

  // Sticky overflow: set by any clamp on an apply step, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
    end else if (apply) begin
      overflow_reg <= overflow_reg | syn_clip | i_clip;
    end
  end

  assign overflow = overflow_reg;
`else
  // Two's-complement wrap: keep the low N bits
  always_comb begin
    syn_next = syn_wide[N-1:0];
    i_next   = sum_wide[N-1:0];
  end

  assign overflow = 1'b0;
`endif

  // Synaptic state, output current and arrival flag advance together on apply
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syn_reg           <= '0;
      i_out_reg         <= '0;
      spike_delayed_reg <= 1'b0;
    end else if (apply) begin
      syn_reg           <= syn_next;
      i_out_reg         <= i_next;
      spike_delayed_reg <= arrive;
    end
  end

  assign i_out         = i_out_reg;
  assign spike_delayed = spike_delayed_reg;

endmodule

// File: tb/tb_spike_synapse.sv
// Directed testbench for spike_synapse: decay, delay, coincidence, saturation,
// inhibition with bias, reset mid-flight and stall behaviour.
module tb_spike_synapse;

  logic        clk;
  logic        reset;
  logic        apply;
  logic        spike_in;
  logic [17:0] weight;
  logic [3:0]  tau_shift;
  logic [3:0]  delay;
  logic [17:0] bias;
  logic [17:0] i_out;
  logic        spike_delayed;
  logic        overflow;

  int checks;
  int failures;

  spike_synapse dut (
    .clk           (clk),
    .reset         (reset),
    .apply         (apply),
    .spike_in      (spike_in),
    .weight        (weight),
    .tau_shift     (tau_shift),
    .delay         (delay),
    .bias          (bias),
    .i_out         (i_out),
    .spike_delayed (spike_delayed),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // One apply step with the given spike level; outputs sampled 1 time unit after the edge
  task automatic do_apply(input logic s);
    @(negedge clk);
    apply    = 1'b1;
    spike_in = s;
    @(posedge clk);
    #1;
    apply    = 1'b0;
    spike_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic setup(input logic [17:0] w, input logic [3:0] t,
                       input logic [3:0] d, input logic [17:0] b);
    weight    = w;
    tau_shift = t;
    delay     = d;
    bias      = b;
  endtask

  logic [17:0] hold_i;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    apply    = 1'b0;
    spike_in = 1'b0;
    setup(18'h0_4000, 4'd2, 4'd0, 18'h0);
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_i_out", 32'(i_out), 32'h0);
    check_val("reset_spike_delayed", 32'(spike_delayed), 32'h0);
    check_val("reset_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Decay: 0.25 then *0.75 each step
    do_apply(1'b1);
    check_val("decay_s0_i_out", 32'(i_out), 32'h0_4000);
    check_val("decay_s0_arrive", 32'(spike_delayed), 32'h1);
    do_apply(1'b0);
    check_val("decay_s1_i_out", 32'(i_out), 32'h0_3000);
    check_val("decay_s1_arrive", 32'(spike_delayed), 32'h0);
    do_apply(1'b0);
    check_val("decay_s2_i_out", 32'(i_out), 32'h0_2400);

    // Delay of 3 with a stall in the middle
    do_reset();
    setup(18'h0_4000, 4'd15, 4'd3, 18'h0);
    do_apply(1'b1);
    check_val("delay_k0_i_out", 32'(i_out), 32'h0);
    check_val("delay_k0_arrive", 32'(spike_delayed), 32'h0);
    do_apply(1'b0);
    check_val("delay_k1_i_out", 32'(i_out), 32'h0);
    check_val("delay_k1_arrive", 32'(spike_delayed), 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      spike_in = c[0];
      @(posedge clk);
      #1;
      check_val("stall_i_out", 32'(i_out), 32'h0);
      check_val("stall_arrive", 32'(spike_delayed), 32'h0);
    end
    spike_in = 1'b0;
    do_apply(1'b0);
    check_val("delay_k2_i_out", 32'(i_out), 32'h0);
    check_val("delay_k2_arrive", 32'(spike_delayed), 32'h0);
    do_apply(1'b0);
    check_val("delay_k3_i_out", 32'(i_out), 32'h0_4000);
    check_val("delay_k3_arrive", 32'(spike_delayed), 32'h1);
    do_apply(1'b0);
    check_val("delay_k4_i_out", 32'(i_out), 32'h0_4000);
    check_val("delay_k4_arrive", 32'(spike_delayed), 32'h0);

    // Stall with nonzero state: nothing moves while apply is low
    hold_i = i_out;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      spike_in = ~c[0];
      @(posedge clk);
      #1;
      check_val("stall2_i_out", 32'(i_out), 32'(hold_i));
      check_val("stall2_arrive", 32'(spike_delayed), 32'h0);
    end
    spike_in = 1'b0;

    // Coincident arrival: in-flight entry plus a zero-delay spike add one weight
    do_reset();
    setup(18'h0_4000, 4'd15, 4'd1, 18'h0);
    do_apply(1'b1);
    check_val("coinc_a0_i_out", 32'(i_out), 32'h0);
    delay = 4'd0;
    do_apply(1'b1);
    check_val("coinc_a1_i_out", 32'(i_out), 32'h0_4000);
    check_val("coinc_a1_arrive", 32'(spike_delayed), 32'h1);
    do_apply(1'b0);
    check_val("coinc_a2_i_out", 32'(i_out), 32'h0_4000);
    check_val("coinc_a2_arrive", 32'(spike_delayed), 32'h0);

    // Saturation: 1.75 + 1.75 - tiny decay
    do_reset();
    setup(18'h1_C000, 4'd15, 4'd0, 18'h0);
    do_apply(1'b1);
    check_val("sat_s0_i_out", 32'(i_out), 32'h1_C000);
    check_val("sat_s0_overflow", 32'(overflow), 32'h0);
    do_apply(1'b1);
`ifdef SPIKE_SYNAPSE_SATURATE_EN
    check_val("sat_s1_i_out", 32'(i_out), 32'h1_FFFF);
    check_val("sat_s1_overflow", 32'(overflow), 32'h1);
    do_apply(1'b0);
    check_val("sat_sticky_overflow", 32'(overflow), 32'h1);
`else
    check_val("wrap_s1_i_out", 32'(i_out), 32'h3_7FFD);
    check_val("wrap_s1_overflow", 32'(overflow), 32'h0);
`endif

    // Inhibition plus bias: -0.25 + 0.15 = -0.1
    do_reset();
    setup(18'h3_C000, 4'd15, 4'd0, 18'h0_2666);
    @(posedge clk);
    #1;
    check_val("bias_pre_apply_i_out", 32'(i_out), 32'h0);
    do_apply(1'b1);
    check_val("inhib_i_out", 32'(i_out), 32'h3_E666);
    check_val("inhib_arrive", 32'(spike_delayed), 32'h1);

    // Reset mid-flight with delay 5
    do_reset();
    setup(18'h0_4000, 4'd15, 4'd5, 18'h0);
    do_apply(1'b1);
    do_apply(1'b0);
    do_apply(1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("midrst_i_out", 32'(i_out), 32'h0);
    check_val("midrst_arrive", 32'(spike_delayed), 32'h0);
    check_val("midrst_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      do_apply(1'b0);
      check_val("postrst_arrive", 32'(spike_delayed), 32'h0);
      check_val("postrst_i_out", 32'(i_out), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
